mmio_iou_n: RTL and testbench
=============================

# mmio_iou_n

Parametrised memory-mapped I/O unit that sits between the CPU data port and the board peripherals: switches, LEDs, push-buttons and the seven-segment hex register. It generalises the fixed two-button, 16-bit I/O unit to configurable switch, LED and button widths. It adds:
- per-button debounce;
- sticky button-event capture;
- valid/ready handshake flags for the switch-input and display channels;
- an optional free-running cycle counter.

The CPU selects this block with `io_we`/`io_rd`; cache traffic never reaches it.

## Interface
Parameters:
- `SW_W`, 16: switch width, 1..32.
- `LED_W`, 16: LED width, 1..32.
- `NBTN`, 2: button count, 2..8. `btn[0]` = commit, `btn[1]` = display-ack, the rest are general purpose.
- `DB_CYC`, 100000: debounce stability cycles, >= 2.

Ports (clock and reset first):
- `clk` in 1: single clock for all state.
- `rstn` in 1: synchronous active-low reset.
- `io_addr` in 32: byte address; only `io_addr[4:2]` is decoded.
- `io_dout` in 32: CPU write data.
- `io_we` in 1: write strobe, one cycle per access.
- `io_rd` in 1: read strobe, one cycle per access.
- `io_din` out 32: read data, combinational from the current register state.
- `sw` in `SW_W`: raw switches.
- `btn` in `NBTN`: raw buttons, asynchronous.
- `led` out `LED_W`: LED register.
- `hex_data` out 32: seven-segment display value.
- `swx_vld` out 1: switch word latched and not yet read.
- `seg_rdy` out 1: display ready for a new value.

## Operation
Register map (word offset `io_addr[4:2]`):
- 0 LED, RW: a write loads `io_dout[LED_W-1:0]`; a read returns the value zero-extended.
- 1 SWX_VLD, R: returns `{31'b0, swx_vld}`.
- 2 SWX_DATA, R: returns the latched switch word, zero-extended. A read clears `swx_vld`.
- 3 SEG_RDY, R: returns `{31'b0, seg_rdy}`.
- 4 SEG_DATA, RW: a write loads `hex_data` and clears `seg_rdy`.
- 5 CYCLES, R: cycle counter (see Configuration).
- 6 BTN_LVL, R: debounced button levels, zero-extended.
- 7 BTN_EVT, R: sticky rising-edge flags, one per button. A read clears them.

Access rules:
- Writes to read-only offsets are ignored.
- `io_we` and `io_rd` are handled independently.
- Read side effects (the clears) take effect at the clock edge where `io_rd` is high.

Button path, per button:
- Two-flop synchroniser, then a debouncer.
- Debouncer: the counter increments while the synchronised level differs from the stable level and resets to 0 when it matches. When the counter reaches `DB_CYC-1`, the stable level toggles and the counter resets.
- A 0->1 stable transition produces a one-cycle `pulse[i]`.

Pulse effects:
- `pulse[0]` latches `sw` into SWX_DATA and sets `swx_vld`. If `swx_vld` is already set, the data is overwritten with the new value.
- `pulse[1]` sets `seg_rdy`.
- Every `pulse[i]` sets `BTN_EVT[i]`.

Simultaneous events:
- Set beats read-clear: a commit pulse coinciding with a SWX_DATA read leaves `swx_vld = 1`. `io_din` in that cycle returns the old data.
- Write-clear beats set: a SEG_DATA write coinciding with an ack pulse leaves `seg_rdy = 0`.
- BTN_EVT: when a read coincides with a pulse, the bit for the pulsing button stays set; the other bits clear.

## Timing
Reset values (`rstn` = 0 at a clock edge):
- `led` = 0, `hex_data` = 0, SWX_DATA = 0.
- `swx_vld` = 0, `seg_rdy` = 1.
- BTN_EVT = 0, cycle counter = 0.
- Debounce counters, synchronisers and stable levels = 0.
- `io_din` = 0 at every offset except SEG_RDY, which reads 1.

Reset behaviour:
- Reset mid-debounce discards the partial count.
- A button held through reset is seen as a fresh press `DB_CYC+3` cycles after release of reset.

Latency:
- Write latency is 1 cycle: the register is visible on `io_din`/outputs after the write edge.
- Read data is valid in the same cycle as `io_rd`.
- Button-to-pulse: if `btn[i]` rises and stays stable before edge k, `pulse[i]` is high in the cycle after edge k+`DB_CYC`+2.
- Pulse-driven flags (`swx_vld`, `seg_rdy`, BTN_EVT) are set one edge after the pulse.

Glitch rejection: a bounce shorter than `DB_CYC` cycles produces no pulse and no level change.

## Configuration
`IOU_CYCLE_CNT_EN`:
- Defined: a 32-bit counter increments every cycle after reset and wraps from 0xFFFFFFFF to 0. It is readable at offset 5.
- Undefined: no counter flops exist and offset 5 reads 0.

## Test plan
Benches use `DB_CYC` = 4, `SW_W` = `LED_W` = 16, `NBTN` = 3.
1. Release reset, then read every offset -> all read 0 except SEG_RDY = 1; `led` = 0, `hex_data` = 0.
2. `sw` = 0xA5C3; hold `btn[0]` high for 10 cycles -> `swx_vld` rises exactly `DB_CYC+3` cycles after the first sampling edge. Read offset 2 -> returns 0x0000A5C3, and `swx_vld` = 0 on the next cycle. Pulse `btn[0]` for 2 cycles -> no change.
3. Write 0x12345678 to offset 4 -> `hex_data` = 0x12345678 and `seg_rdy` = 0. Press `btn[1]` -> `seg_rdy` = 1. Repeat with the write landing in the same cycle as the ack pulse -> `seg_rdy` = 0.
4. Write 0xFFFF_BEEF to offset 0 -> `led` = 0xBEEF, read back 0x0000BEEF. Write offset 1 -> no state change.
5. Press `btn[2]` -> BTN_EVT = 0x4 and BTN_LVL = 0x4. Read offset 7 -> returns 0x4, then 0. Repeat with the read coinciding with a `btn[0]` pulse -> bit 0 is retained.
6. With `IOU_CYCLE_CNT_EN` defined -> two reads 10 cycles apart differ by 10. Force the counter to 0xFFFFFFFE -> it wraps to 0 after 2 cycles. With the macro undefined -> offset 5 reads 0.

Source files
------------

// File: rtl/mmio_iou_n.sv
// Memory-mapped I/O unit: LEDs, switches, debounced buttons, hex display, optional cycle counter.
// Latency: writes visible one edge after io_we, reads combinational, button-to-pulse DB_CYC+3 edges.
// Flow control: swx_vld/seg_rdy flags are set by button pulses and cleared by CPU read/write. Optional macro: IOU_CYCLE_CNT_EN.
module mmio_iou_n #(
  parameter int SW_W   = 16,
  parameter int LED_W  = 16,
  parameter int NBTN   = 2,
  parameter int DB_CYC = 100000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  input  logic             io_rd,
  output logic [31:0]      io_din,
  input  logic [SW_W-1:0]  sw,
  input  logic [NBTN-1:0]  btn,
  output logic [LED_W-1:0] led,
  output logic [31:0]      hex_data,
  output logic             swx_vld,
  output logic             seg_rdy
);

  localparam int CW = $clog2(DB_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYC - 1);

  localparam logic [2:0] OFF_LED      = 3'd0;
  localparam logic [2:0] OFF_SWX_VLD  = 3'd1;
  localparam logic [2:0] OFF_SWX_DATA = 3'd2;
  localparam logic [2:0] OFF_SEG_RDY  = 3'd3;
  localparam logic [2:0] OFF_SEG_DATA = 3'd4;
  localparam logic [2:0] OFF_CYCLES   = 3'd5;
  localparam logic [2:0] OFF_BTN_LVL  = 3'd6;
  localparam logic [2:0] OFF_BTN_EVT  = 3'd7;

  logic [2:0] off;
  assign off = io_addr[4:2];

  // Only the word offset is decoded; the remaining address bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{io_addr[31:5], io_addr[1:0]};

  logic [NBTN-1:0] sync1, sync2, stable, stable_d, pulse;
  logic [CW-1:0]   db_cnt [NBTN];

  logic [LED_W-1:0] led_q;
  logic [31:0]      hex_q;
  logic [SW_W-1:0]  swx_dat;
  logic             swx_vld_q;
  logic             seg_rdy_q;
  logic [NBTN-1:0]  btn_evt;
  logic [31:0]      cycle_val;

  // Synchronise, debounce and edge-detect every button; pulse is a registered one-cycle 0->1 strobe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      pulse    <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == CNT_MAX) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // CPU-visible registers; pulse sets beat read-clears, but a SEG_DATA write beats the ack set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      led_q     <= '0;
      hex_q     <= '0;
      swx_dat   <= '0;
      swx_vld_q <= 1'b0;
      seg_rdy_q <= 1'b1;
      btn_evt   <= '0;
    end else begin
      if (io_we && off == OFF_LED) led_q <= io_dout[LED_W-1:0];

      if (io_we && off == OFF_SEG_DATA) begin
        hex_q     <= io_dout;
        seg_rdy_q <= 1'b0;
      end else if (pulse[1]) begin
        seg_rdy_q <= 1'b1;
      end

      if (pulse[0]) begin
        swx_dat   <= sw;
        swx_vld_q <= 1'b1;
      end else if (io_rd && off == OFF_SWX_DATA) begin
        swx_vld_q <= 1'b0;
      end

      if (io_rd && off == OFF_BTN_EVT) btn_evt <= pulse;
      else                             btn_evt <= btn_evt | pulse;
    end
  end

`ifdef IOU_CYCLE_CNT_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // Read mux: combinational view of current register state, zero-extended.
  always_comb begin
    io_din = '0;
    case (off)
      OFF_LED:      io_din[LED_W-1:0] = led_q;
      OFF_SWX_VLD:  io_din[0]         = swx_vld_q;
      OFF_SWX_DATA: io_din[SW_W-1:0]  = swx_dat;
      OFF_SEG_RDY:  io_din[0]         = seg_rdy_q;
      OFF_SEG_DATA: io_din            = hex_q;
      OFF_CYCLES:   io_din            = cycle_val;
      OFF_BTN_LVL:  io_din[NBTN-1:0]  = stable;
      OFF_BTN_EVT:  io_din[NBTN-1:0]  = btn_evt;
    endcase
  end

  assign led      = led_q;
  assign hex_data = hex_q;
  assign swx_vld  = swx_vld_q;
  assign seg_rdy  = seg_rdy_q;

endmodule

// File: tb/tb_mmio_iou_n.sv
// Bench for mmio_iou_n with DB_CYC=4, 16-bit switches/LEDs, three buttons.
// Reads push their expected value into a queue; a negedge monitor pops and compares io_din.
// Multi-cycle corners (debounce timing, glitch, collisions) are hand-written sequences.
module tb_mmio_iou_n;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;
  logic [15:0] sw;
  logic [2:0]  btn;
  logic [15:0] led;
  logic [31:0] hex_data;
  logic        swx_vld;
  logic        seg_rdy;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [31:0] c0, c1;

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] wdat;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t rst_tab[8];
  vec_t reg_tab[7];

  mmio_iou_n #(.SW_W(16), .LED_W(16), .NBTN(3), .DB_CYC(4)) dut (
    .clk(clk), .rstn(rstn),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd),
    .io_din(io_din), .sw(sw), .btn(btn), .led(led), .hex_data(hex_data),
    .swx_vld(swx_vld), .seg_rdy(seg_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every cycle with io_rd high consumes one expected read value.
  always @(negedge clk) begin
    if (io_rd) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk(nm_q.pop_front(), io_din, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string nm);
    io_addr = {27'd0, off, 2'b00};
    io_rd   = 1'b1;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    cyc();
    io_rd   = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] dat);
    io_addr = {27'd0, off, 2'b00};
    io_dout = dat;
    io_we   = 1'b1;
    cyc();
    io_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_tab[0] = '{1'b0, 3'd0, 32'd0, 32'd0, "rst_led"};
    rst_tab[1] = '{1'b0, 3'd1, 32'd0, 32'd0, "rst_swx_vld"};
    rst_tab[2] = '{1'b0, 3'd2, 32'd0, 32'd0, "rst_swx_dat"};
    rst_tab[3] = '{1'b0, 3'd3, 32'd0, 32'd1, "rst_seg_rdy"};
    rst_tab[4] = '{1'b0, 3'd4, 32'd0, 32'd0, "rst_seg_dat"};
    rst_tab[5] = '{1'b0, 3'd5, 32'd0, 32'd0, "rst_cycles"};
    rst_tab[6] = '{1'b0, 3'd6, 32'd0, 32'd0, "rst_btn_lvl"};
    rst_tab[7] = '{1'b0, 3'd7, 32'd0, 32'd0, "rst_btn_evt"};

    reg_tab[0] = '{1'b1, 3'd0, 32'hFFFF_BEEF, 32'h0000_BEEF, "led_rw"};
    reg_tab[1] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_0000, "swx_vld_ro"};
    reg_tab[2] = '{1'b1, 3'd2, 32'h0000_0000, 32'h0000_5A5A, "swx_dat_ro"};
    reg_tab[3] = '{1'b1, 3'd3, 32'h0000_0001, 32'h0000_0000, "seg_rdy_ro"};
    reg_tab[4] = '{1'b1, 3'd6, 32'h0000_0007, 32'h0000_0000, "btn_lvl_ro"};
    reg_tab[5] = '{1'b0, 3'd4, 32'h0000_0000, 32'hCAFE_0001, "seg_dat_hold"};
    reg_tab[6] = '{1'b1, 3'd0, 32'h0001_0003, 32'h0000_0003, "led_trunc"};

    rstn = 1'b0; io_addr = '0; io_dout = '0; io_we = 1'b0; io_rd = 1'b0;
    sw = '0; btn = '0;

    // 1: reset state, read while reset is held so the counter is still 0
    repeat (3) cyc();
    for (int i = 0; i < 8; i++) rd(rst_tab[i].off, rst_tab[i].exp, rst_tab[i].nm);
    chk("rst_led_out", {16'd0, led}, 32'd0);
    chk("rst_hex_out", hex_data, 32'd0);
    chk("rst_swx_vld_out", {31'd0, swx_vld}, 32'd0);
    chk("rst_seg_rdy_out", {31'd0, seg_rdy}, 32'd1);
    rstn = 1'b1;
    cyc();

    // 2: commit timing, read-clear, glitch rejection, set-beats-clear
    sw = 16'hA5C3;
    btn[0] = 1'b1;
    repeat (7) cyc();
    chk("swx_vld_early", {31'd0, swx_vld}, 32'd0);
    cyc();
    chk("swx_vld_rise", {31'd0, swx_vld}, 32'd1);
    repeat (2) cyc();
    btn[0] = 1'b0;
    repeat (10) cyc();
    rd(3'd2, 32'h0000_A5C3, "swx_dat_read");
    chk("swx_vld_clr", {31'd0, swx_vld}, 32'd0);

    sw = 16'h1111;
    btn[0] = 1'b1;
    repeat (2) cyc();
    btn[0] = 1'b0;
    repeat (12) cyc();
    chk("glitch_vld", {31'd0, swx_vld}, 32'd0);
    rd(3'd6, 32'd0, "glitch_lvl");
    rd(3'd2, 32'h0000_A5C3, "glitch_dat");

    sw = 16'h5A5A;
    btn[0] = 1'b1;
    repeat (7) cyc();
    rd(3'd2, 32'h0000_A5C3, "swx_coll_old");
    chk("swx_coll_vld", {31'd0, swx_vld}, 32'd1);
    repeat (3) cyc();
    btn[0] = 1'b0;
    repeat (10) cyc();
    rd(3'd1, 32'd1, "swx_vld_rd");
    rd(3'd2, 32'h0000_5A5A, "swx_coll_new");
    chk("swx_vld_clr2", {31'd0, swx_vld}, 32'd0);

    // 3: display handshake and write-beats-ack collision
    wr(3'd4, 32'h1234_5678);
    chk("hex_wr", hex_data, 32'h1234_5678);
    chk("seg_rdy_wr", {31'd0, seg_rdy}, 32'd0);
    rd(3'd3, 32'd0, "seg_rdy_rd");
    btn[1] = 1'b1;
    repeat (10) cyc();
    chk("seg_rdy_ack", {31'd0, seg_rdy}, 32'd1);
    btn[1] = 1'b0;
    repeat (10) cyc();
    btn[1] = 1'b1;
    repeat (7) cyc();
    wr(3'd4, 32'hCAFE_0001);
    chk("seg_coll_rdy", {31'd0, seg_rdy}, 32'd0);
    chk("seg_coll_hex", hex_data, 32'hCAFE_0001);
    repeat (3) cyc();
    chk("seg_coll_hold", {31'd0, seg_rdy}, 32'd0);
    btn[1] = 1'b0;
    repeat (10) cyc();

    // 4: register access table, read-only offsets ignore writes
    wr(3'd0, 32'hFFFF_BEEF);
    chk("led_out", {16'd0, led}, 32'h0000_BEEF);
    for (int i = 0; i < 7; i++) begin
      if (reg_tab[i].we) wr(reg_tab[i].off, reg_tab[i].wdat);
      rd(reg_tab[i].off, reg_tab[i].exp, reg_tab[i].nm);
    end
    chk("led_trunc_out", {16'd0, led}, 32'h0000_0003);

    // 5: button events
    rd(3'd7, 32'h3, "evt_prior");
    rd(3'd7, 32'h0, "evt_cleared");
    btn[2] = 1'b1;
    repeat (10) cyc();
    rd(3'd6, 32'h4, "lvl_btn2");
    rd(3'd7, 32'h4, "evt_btn2");
    rd(3'd7, 32'h0, "evt_btn2_clr");
    btn[2] = 1'b0;
    repeat (10) cyc();
    rd(3'd6, 32'h0, "lvl_btn2_rel");
    btn[2] = 1'b1;
    repeat (10) cyc();
    btn[2] = 1'b0;
    repeat (10) cyc();
    sw = 16'h0F0F;
    btn[0] = 1'b1;
    repeat (7) cyc();
    rd(3'd7, 32'h4, "evt_coll_old");
    rd(3'd7, 32'h1, "evt_coll_keep");
    btn[0] = 1'b0;
    repeat (10) cyc();
    rd(3'd2, 32'h0000_0F0F, "evt_coll_sw");

    // 6: cycle counter
`ifdef IOU_CYCLE_CNT_EN
    io_addr = {27'd0, 3'd5, 2'b00};
    c0 = io_din;
    repeat (10) cyc();
    c1 = io_din;
    chk("cyc_delta", c1 - c0, 32'd10);
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    cyc();
    chk("cyc_max", io_din, 32'hFFFF_FFFF);
    cyc();
    chk("cyc_wrap", io_din, 32'h0000_0000);
`else
    rd(3'd5, 32'd0, "cyc_absent");
`endif

    chk("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
